// File: rtl/mips_pkg.sv
// Shared MIPS pipeline definitions: write-back result-select encodings,
// register-file constants and the link-address helper.
package mips_pkg;

    localparam logic [1:0] MTR_ALU  = 2'b00;
    localparam logic [1:0] MTR_DM   = 2'b01;
    localparam logic [1:0] MTR_LINK = 2'b10;
    localparam logic [1:0] MTR_IMM  = 2'b11;

    localparam logic [4:0] REG_ZERO = 5'd0;
    localparam int         NUM_GPR  = 32;

    // jal/jalr link value is PC+8, i.e. the W-stage PC+4 plus one more word
    function automatic logic [31:0] link_value(input logic [31:0] pc4);
        return pc4 + 32'd4;
    endfunction

endpackage

// File: rtl/wb_data_mux.sv
// W-stage result select: 4:1 mux over ALU result, DM data, link value and
// immediate. Shared with the forwarding unit so both see identical data.
module wb_data_mux (
    input  logic [31:0] pc4,
    input  logic [31:0] alu_out,
    input  logic [31:0] dr,
    input  logic [31:0] imm,
    input  logic [1:0]  mem_to_reg,
    output logic [31:0] wd
);
    import mips_pkg::*;

    // result select
    always_comb begin
        wd = 32'd0;
        case (mem_to_reg)
            MTR_ALU:  wd = alu_out;
            MTR_DM:   wd = dr;
            MTR_LINK: wd = link_value(pc4);
            MTR_IMM:  wd = imm;
            default:  wd = 32'd0;
        endcase
    end

endmodule

// File: rtl/wb_regfile.sv
// Write-back stage: GPR file with write-through bypass to the D-stage read
// ports, plus a retired-instruction counter for trace/debug.
module wb_regfile #(
    parameter int NUM_GPR = 32,
    parameter int CNT_W   = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [31:0]      PC4_W,
    input  logic [31:0]      IR_W,
    input  logic [31:0]      ALUOut_W,
    input  logic [31:0]      DR_W,
    input  logic [31:0]      imm_W,
    input  logic [4:0]       WA_W,
    input  logic             RegWrite_W,
    input  logic [1:0]       MemtoReg_W,
    input  logic [4:0]       RA1,
    input  logic [4:0]       RA2,
    output logic [31:0]      RD1,
    output logic [31:0]      RD2,
    output logic [31:0]      WD_W,
    output logic [CNT_W-1:0] retired
);
    import mips_pkg::*;

    logic [31:0]      gpr_r [NUM_GPR];
    logic [CNT_W-1:0] retired_r;
    logic             we_s;

    wb_data_mux u_wb_data_mux (
        .pc4        (PC4_W),
        .alu_out    (ALUOut_W),
        .dr         (DR_W),
        .imm        (imm_W),
        .mem_to_reg (MemtoReg_W),
        .wd         (WD_W)
    );

    // writes to $0 are dropped here so storage for $0 never changes
    always_comb begin
        we_s = RegWrite_W && (WA_W != REG_ZERO);
    end

    // GPR storage; reset clears every register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NUM_GPR; i++) begin
                gpr_r[i] <= 32'd0;
            end
        end else if (we_s) begin
            gpr_r[WA_W] <= WD_W;
        end
    end

    // read port 1 with same-cycle write-through bypass
    always_comb begin
        if (RA1 == REG_ZERO) begin
            RD1 = 32'd0;
        end else if (we_s && (RA1 == WA_W)) begin
            RD1 = WD_W;
        end else begin
            RD1 = gpr_r[RA1];
        end
    end

    // read port 2, independent of port 1
    always_comb begin
        if (RA2 == REG_ZERO) begin
            RD2 = 32'd0;
        end else if (we_s && (RA2 == WA_W)) begin
            RD2 = WD_W;
        end else begin
            RD2 = gpr_r[RA2];
        end
    end

    // retire counter: any non-bubble W instruction counts, wrapping silently
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            retired_r <= {CNT_W{1'b0}};
        end else if (IR_W != 32'd0) begin
            retired_r <= retired_r + CNT_W'(1);
        end
    end

    assign retired = retired_r;

endmodule

// File: tb/tb_wb_regfile.sv
// Self-checking bench for wb_regfile: directed scenarios plus randomized
// traffic against an array-based reference model of the register file.
module tb_wb_regfile;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] PC4_W = 32'd0, IR_W = 32'd0, ALUOut_W = 32'd0, DR_W = 32'd0, imm_W = 32'd0;
    logic [4:0]  WA_W = 5'd0, RA1 = 5'd0, RA2 = 5'd0;
    logic        RegWrite_W = 1'b0;
    logic [1:0]  MemtoReg_W = 2'b00;
    logic [31:0] RD1, RD2, WD_W, retired;
    logic [31:0] s_rd1, s_rd2, s_wd;
    logic [2:0]  s_retired;

    int n_checks = 0;
    int n_pass   = 0;

    logic [31:0] m_gpr [32];
    logic [31:0] m_ret = 32'd0;
    logic [2:0]  m_ret_s = 3'd0;

    wb_regfile dut (
        .clk(clk), .reset(reset), .PC4_W(PC4_W), .IR_W(IR_W), .ALUOut_W(ALUOut_W),
        .DR_W(DR_W), .imm_W(imm_W), .WA_W(WA_W), .RegWrite_W(RegWrite_W),
        .MemtoReg_W(MemtoReg_W), .RA1(RA1), .RA2(RA2), .RD1(RD1), .RD2(RD2),
        .WD_W(WD_W), .retired(retired)
    );

    // narrow counter instance so the wrap can be reached in a few cycles
    wb_regfile #(.CNT_W(3)) dut_small (
        .clk(clk), .reset(reset), .PC4_W(PC4_W), .IR_W(IR_W), .ALUOut_W(ALUOut_W),
        .DR_W(DR_W), .imm_W(imm_W), .WA_W(WA_W), .RegWrite_W(RegWrite_W),
        .MemtoReg_W(MemtoReg_W), .RA1(RA1), .RA2(RA2), .RD1(s_rd1), .RD2(s_rd2),
        .WD_W(s_wd), .retired(s_retired)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] model_wd();
        case (MemtoReg_W)
            2'd0:    return ALUOut_W;
            2'd1:    return DR_W;
            2'd2:    return PC4_W + 32'd4;
            default: return imm_W;
        endcase
    endfunction

    function automatic logic [31:0] model_rd(input logic [4:0] ra);
        if (ra == 5'd0) return 32'd0;
        if (RegWrite_W && WA_W != 5'd0 && WA_W == ra) return model_wd();
        return m_gpr[ra];
    endfunction

    task automatic model_clear();
        for (int i = 0; i < 32; i++) m_gpr[i] = 32'd0;
        m_ret   = 32'd0;
        m_ret_s = 3'd0;
    endtask

    // one clock: model commits on the rising edge, returns at the falling edge
    task automatic step();
        @(posedge clk);
        if (reset) begin
            if (RegWrite_W && WA_W != 5'd0) m_gpr[WA_W] = model_wd();
            if (IR_W != 32'd0) begin
                m_ret   = m_ret + 32'd1;
                m_ret_s = m_ret_s + 3'd1;
            end
        end
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        RegWrite_W = 1'b0; IR_W = 32'd0; WA_W = 5'd0; MemtoReg_W = 2'b00;
    endtask

    task automatic test_reset();
        model_clear();
        #1;
        n_checks++; if (retired !== 32'd0) $display("FAIL reset_retired got=%h exp=%h", retired, 32'd0); else n_pass++;
        for (int a = 1; a < 32; a += 10) begin
            RA1 = 5'(a); RA2 = 5'(31 - a); #1;
            n_checks++; if (RD1 !== 32'd0) $display("FAIL reset_rd1 a=%0d got=%h exp=%h", a, RD1, 32'd0); else n_pass++;
            n_checks++; if (RD2 !== 32'd0) $display("FAIL reset_rd2 a=%0d got=%h exp=%h", a, RD2, 32'd0); else n_pass++;
        end
        @(negedge clk);
        reset = 1'b1;
        // first write accepted on the first edge after release
        RegWrite_W = 1'b1; WA_W = 5'd3; MemtoReg_W = 2'b00; ALUOut_W = 32'h0BAD_F00D;
        step();
        idle_inputs(); RA1 = 5'd3; #1;
        n_checks++; if (RD1 !== model_rd(5'd3)) $display("FAIL first_write got=%h exp=%h", RD1, model_rd(5'd3)); else n_pass++;
    endtask

    task automatic test_bypass_alu();
        MemtoReg_W = 2'b00; ALUOut_W = 32'h1234_5678; WA_W = 5'd8; RegWrite_W = 1'b1; RA1 = 5'd8; #1;
        n_checks++; if (RD1 !== 32'h1234_5678) $display("FAIL bypass_rd1 got=%h exp=%h", RD1, 32'h1234_5678); else n_pass++;
        step();
        RegWrite_W = 1'b0; ALUOut_W = 32'h0; #1;
        n_checks++; if (RD1 !== 32'h1234_5678) $display("FAIL stored_rd1 got=%h exp=%h", RD1, 32'h1234_5678); else n_pass++;
    endtask

    task automatic test_link();
        MemtoReg_W = 2'b10; PC4_W = 32'h0000_3004; WA_W = 5'd31; RegWrite_W = 1'b1; #1;
        n_checks++; if (WD_W !== 32'h0000_3008) $display("FAIL link_wd got=%h exp=%h", WD_W, 32'h0000_3008); else n_pass++;
        step();
        RegWrite_W = 1'b0; PC4_W = 32'hFFFF_FFFC; RA2 = 5'd31; #1;
        n_checks++; if (RD2 !== 32'h0000_3008) $display("FAIL link_stored got=%h exp=%h", RD2, 32'h0000_3008); else n_pass++;
        n_checks++; if (WD_W !== 32'h0000_0000) $display("FAIL link_wrap got=%h exp=%h", WD_W, 32'h0000_0000); else n_pass++;
    endtask

    task automatic test_zero_reg();
        WA_W = 5'd0; RegWrite_W = 1'b1; DR_W = 32'hDEAD_BEEF; MemtoReg_W = 2'b01; RA1 = 5'd0; RA2 = 5'd0; #1;
        n_checks++; if (RD1 !== 32'd0 || RD2 !== 32'd0) $display("FAIL zero_before rd1=%h rd2=%h exp=0", RD1, RD2); else n_pass++;
        n_checks++; if (WD_W !== 32'hDEAD_BEEF) $display("FAIL zero_wd got=%h exp=%h", WD_W, 32'hDEAD_BEEF); else n_pass++;
        step();
        RegWrite_W = 1'b0; #1;
        n_checks++; if (RD1 !== 32'd0 || RD2 !== 32'd0) $display("FAIL zero_after rd1=%h rd2=%h exp=0", RD1, RD2); else n_pass++;
    endtask

    task automatic test_retire();
        logic [31:0] base;
        idle_inputs();
        base = retired;
        for (int i = 0; i < 10; i++) begin
            IR_W = (i % 2 == 0) ? 32'h2408_0001 : 32'd0;
            step();
        end
        IR_W = 32'd0; #1;
        n_checks++; if (retired !== base + 32'd5) $display("FAIL retire_5 got=%h exp=%h", retired, base + 32'd5); else n_pass++;
        n_checks++; if (retired !== m_ret) $display("FAIL retire_model got=%h exp=%h", retired, m_ret); else n_pass++;
    endtask

    task automatic test_retire_wrap();
        IR_W = 32'h2408_0001;
        for (int i = 0; i < 8 && m_ret_s != 3'd7; i++) step();
        #1;
        n_checks++; if (s_retired !== 3'd7) $display("FAIL wrap_top got=%h exp=%h", s_retired, 3'd7); else n_pass++;
        step();
        IR_W = 32'd0; #1;
        n_checks++; if (s_retired !== 3'd0) $display("FAIL wrap_zero got=%h exp=%h", s_retired, 3'd0); else n_pass++;
    endtask

    task automatic test_imm_storage();
        MemtoReg_W = 2'b11; imm_W = 32'hABCD_0000; WA_W = 5'd9; RegWrite_W = 1'b1;
        step();
        WA_W = 5'd10; MemtoReg_W = 2'b00; ALUOut_W = 32'h5555_5555; RA2 = 5'd9; #1;
        n_checks++; if (RD2 !== 32'hABCD_0000) $display("FAIL imm_stored got=%h exp=%h", RD2, 32'hABCD_0000); else n_pass++;
        step();
        idle_inputs();
    endtask

    task automatic test_back_to_back();
        MemtoReg_W = 2'b00; RegWrite_W = 1'b1; WA_W = 5'd12; ALUOut_W = 32'h1111_1111;
        step();
        ALUOut_W = 32'h2222_2222; RA1 = 5'd12; RA2 = 5'd12; #1;
        n_checks++; if (RD1 !== 32'h2222_2222) $display("FAIL b2b_bypass got=%h exp=%h", RD1, 32'h2222_2222); else n_pass++;
        n_checks++; if (RD2 !== RD1 || RD2 !== 32'h2222_2222) $display("FAIL b2b_same_port got=%h exp=%h", RD2, 32'h2222_2222); else n_pass++;
        step();
        RegWrite_W = 1'b0; #1;
        n_checks++; if (RD1 !== 32'h2222_2222) $display("FAIL b2b_last_wins got=%h exp=%h", RD1, 32'h2222_2222); else n_pass++;
    endtask

    task automatic test_random();
        for (int c = 0; c < 300; c++) begin
            PC4_W = $urandom; ALUOut_W = $urandom; DR_W = $urandom; imm_W = $urandom;
            MemtoReg_W = 2'($urandom_range(0, 3));
            WA_W = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
            RegWrite_W = 1'($urandom_range(0, 1));
            IR_W = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom;
            RA1 = ($urandom_range(0, 2) == 0) ? WA_W : 5'($urandom_range(0, 31));
            RA2 = ($urandom_range(0, 2) == 0) ? WA_W : 5'($urandom_range(0, 31));
            #1;
            n_checks++; if (WD_W !== model_wd()) $display("FAIL rand_wd c=%0d got=%h exp=%h", c, WD_W, model_wd()); else n_pass++;
            n_checks++; if (RD1 !== model_rd(RA1)) $display("FAIL rand_rd1 c=%0d ra=%0d got=%h exp=%h", c, RA1, RD1, model_rd(RA1)); else n_pass++;
            n_checks++; if (RD2 !== model_rd(RA2)) $display("FAIL rand_rd2 c=%0d ra=%0d got=%h exp=%h", c, RA2, RD2, model_rd(RA2)); else n_pass++;
            n_checks++; if (retired !== m_ret) $display("FAIL rand_retired c=%0d got=%h exp=%h", c, retired, m_ret); else n_pass++;
            step();
        end
        idle_inputs();
    endtask

    task automatic test_reset_mid();
        // drive a live write, then drop reset partway through the cycle
        MemtoReg_W = 2'b00; ALUOut_W = 32'hCAFE_0005; WA_W = 5'd5; RegWrite_W = 1'b1; IR_W = 32'h2408_0001;
        #2 reset = 1'b0;
        model_clear();
        #1;
        n_checks++; if (retired !== 32'd0 || s_retired !== 3'd0) $display("FAIL rst_mid_retired got=%h/%h exp=0", retired, s_retired); else n_pass++;
        RA1 = 5'd5; #1;
        n_checks++; if (RD1 !== model_rd(5'd5)) $display("FAIL rst_mid_bypass got=%h exp=%h", RD1, model_rd(5'd5)); else n_pass++;
        RegWrite_W = 1'b0;
        for (int a = 1; a < 32; a++) begin
            RA1 = 5'(a); RA2 = 5'(32 - a); #0.1;
            n_checks++; if (RD1 !== 32'd0 || RD2 !== 32'd0) $display("FAIL rst_mid_rd a=%0d rd1=%h rd2=%h exp=0", a, RD1, RD2); else n_pass++;
        end
        // edges under reset must neither write nor count
        RegWrite_W = 1'b1;
        step();
        RegWrite_W = 1'b0; RA1 = 5'd5; #1;
        n_checks++; if (RD1 !== 32'd0) $display("FAIL rst_hold_write got=%h exp=%h", RD1, 32'd0); else n_pass++;
        n_checks++; if (retired !== 32'd0) $display("FAIL rst_hold_count got=%h exp=%h", retired, 32'd0); else n_pass++;
        reset = 1'b1;
        RegWrite_W = 1'b1; ALUOut_W = 32'h7777_0005;
        step();
        RegWrite_W = 1'b0; IR_W = 32'd0; #1;
        n_checks++; if (RD1 !== m_gpr[5]) $display("FAIL rst_release_write got=%h exp=%h", RD1, m_gpr[5]); else n_pass++;
        n_checks++; if (retired !== 32'd1) $display("FAIL rst_release_count got=%h exp=%h", retired, 32'd1); else n_pass++;
    endtask

    initial begin
        test_reset();
        @(negedge clk);
        test_bypass_alu();
        test_link();
        test_zero_reg();
        test_retire();
        test_retire_wrap();
        test_imm_storage();
        test_back_to_back();
        test_random();
        @(negedge clk);
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
